// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU issue controller and its condition evaluator.
//   - alu_op_e    : 3-bit ALU control encodings understood by the external ALU
//   - cond_e      : ARM condition codes EQ..NV
//   - nzvc_t      : architectural flag bundle {n, z, v, c}
//   - is_legal_op : 1 for the six encodings the ALU implements
//   - is_arith_op : 1 for ADD/SUB, the only ops that produce meaningful V/C
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 64;

  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    XOR    = 3'b110
  } alu_op_e;

  typedef enum logic [3:0] {
    EQ = 4'd0,
    NE = 4'd1,
    CS = 4'd2,
    CC = 4'd3,
    MI = 4'd4,
    PL = 4'd5,
    VS = 4'd6,
    VC = 4'd7,
    HI = 4'd8,
    LS = 4'd9,
    GE = 4'd10,
    LT = 4'd11,
    GT = 4'd12,
    LE = 4'd13,
    AL = 4'd14,
    NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;

  // 3'b001 and 3'b111 have no ALU function behind them.
  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      PASS_B, ADD, SUB, AND, OR, XOR: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
//   Purely combinational ARM condition-code evaluator used for B.cond.
//   Ports:
//     cond_i  : condition code to test (EQ..NV)
//     flags_i : current architectural flags {n, z, v, c}
//     taken_o : 1 when the condition holds (AL and NV are always taken)
// ---------------------------------------------------------------------------
module cond_eval
  import alu_pkg::*;
(
  input  cond_e cond_i,
  input  nzvc_t flags_i,
  output logic  taken_o
);

  always_comb begin
    taken_o = 1'b1;
    unique case (cond_i)
      EQ: taken_o = flags_i.z;
      NE: taken_o = !flags_i.z;
      CS: taken_o = flags_i.c;
      CC: taken_o = !flags_i.c;
      MI: taken_o = flags_i.n;
      PL: taken_o = !flags_i.n;
      VS: taken_o = flags_i.v;
      VC: taken_o = !flags_i.v;
      HI: taken_o = flags_i.c && !flags_i.z;
      LS: taken_o = !flags_i.c || flags_i.z;
      GE: taken_o = (flags_i.n == flags_i.v);
      LT: taken_o = (flags_i.n != flags_i.v);
      GT: taken_o = !flags_i.z && (flags_i.n == flags_i.v);
      LE: taken_o = flags_i.z || (flags_i.n != flags_i.v);
      AL: taken_o = 1'b1;
      NV: taken_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Issues ops from a valid/ready stream to an external combinational ALU and
//   returns the captured result as a valid/ready response. Two stages:
//     EX : registered ALU operands (alu_a/alu_b/alu_cntrl drive the ALU)
//     WB : registered response, captured from the ALU outputs
//   Also owns the architectural NZVC flags (updated at WB capture, in program
//   order) and evaluates B.cond ops against them.
//   Ports:
//     clk, reset_n                   clock, asynchronous active-low reset
//     req_valid/req_ready            op request handshake
//     req_cntrl, req_a, req_b        ALU op and operands
//     req_setflags, req_is_bcond     flag update / branch-condition op
//     req_cond                       condition code for B.cond
//     flush                          kills the op currently in EX
//     alu_a, alu_b, alu_cntrl        to ALU (EX registers)
//     alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out  from ALU
//     rsp_valid/rsp_ready            response handshake
//     rsp_result, rsp_taken, rsp_illegal  response payload
//     flags_nzvc                     architectural flags {N,Z,V,C}
// ---------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cntrl,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_setflags,
  input  logic             req_is_bcond,
  input  logic [3:0]       req_cond,
  input  logic             flush,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_taken,
  output logic             rsp_illegal,
  output logic [3:0]       flags_nzvc
);

  // EX stage
  logic             ex_valid_q,    ex_valid_d;
  logic [WIDTH-1:0] alu_a_q,       alu_a_d;
  logic [WIDTH-1:0] alu_b_q,       alu_b_d;
  logic [2:0]       alu_cntrl_q,   alu_cntrl_d;
  logic             ex_setflags_q, ex_setflags_d;
  logic             ex_bcond_q,    ex_bcond_d;
  cond_e            ex_cond_q,     ex_cond_d;

  // WB stage and architectural flags
  logic             rsp_valid_q,   rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q,  rsp_result_d;
  logic             rsp_taken_q,   rsp_taken_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  nzvc_t            flags_q,       flags_d;

  logic wb_free;
  logic accept;
  logic ex_move;
  logic ex_legal;
  logic bcond_taken;

  // WB can take a new op when empty or draining this cycle. EX can take a
  // new op when empty or when its current op is leaving (or being flushed,
  // which also requires wb_free through req_ready -- kept simple on purpose
  // so req_ready never depends on req_valid or flush).
  assign wb_free   = !rsp_valid_q || rsp_ready;
  assign req_ready = !ex_valid_q || wb_free;
  assign accept    = req_valid && req_ready;
  assign ex_move   = ex_valid_q && wb_free && !flush;
  assign ex_legal  = is_legal_op(alu_cntrl_q);

  // The B.cond sees flags_q as they stand at its own capture edge, which
  // already includes every older op captured on earlier edges.
  cond_eval u_cond_eval (
    .cond_i  (ex_cond_q),
    .flags_i (flags_q),
    .taken_o (bcond_taken)
  );

  always_comb begin
    ex_valid_d    = ex_valid_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cntrl_d   = alu_cntrl_q;
    ex_setflags_d = ex_setflags_q;
    ex_bcond_d    = ex_bcond_q;
    ex_cond_d     = ex_cond_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_taken_d   = rsp_taken_q;
    rsp_illegal_d = rsp_illegal_q;
    flags_d       = flags_q;

    // EX: a new op always wins; otherwise the slot empties when its op moves
    // on or is flushed. A flush with a simultaneous accept only kills the
    // older op, which is simply overwritten here.
    if (accept) begin
      ex_valid_d    = 1'b1;
      alu_a_d       = req_a;
      alu_b_d       = req_b;
      alu_cntrl_d   = req_cntrl;
      ex_setflags_d = req_setflags;
      ex_bcond_d    = req_is_bcond;
      ex_cond_d     = cond_e'(req_cond);
    end else if (flush || ex_move) begin
      ex_valid_d = 1'b0;
    end

    // WB: response payload only changes when the slot is free; otherwise it
    // holds until the consumer takes it.
    if (wb_free) begin
      rsp_valid_d = ex_move;
    end

    if (ex_move) begin
      rsp_result_d  = ex_legal ? alu_result : '0;
      rsp_taken_d   = ex_bcond_q && bcond_taken;
      rsp_illegal_d = !ex_legal;

      if (ex_setflags_q && !ex_bcond_q && ex_legal) begin
        flags_d.n = alu_negative;
        flags_d.z = alu_zero;
        // Logical ops and PASS_B do not define V/C; clear them.
        if (is_arith_op(alu_cntrl_q)) begin
          flags_d.v = alu_overflow;
          flags_d.c = alu_carry_out;
        end else begin
          flags_d.v = 1'b0;
          flags_d.c = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cntrl_q   <= '0;
      ex_setflags_q <= 1'b0;
      ex_bcond_q    <= 1'b0;
      ex_cond_q     <= EQ;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      flags_q       <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cntrl_q   <= alu_cntrl_d;
      ex_setflags_q <= ex_setflags_d;
      ex_bcond_q    <= ex_bcond_d;
      ex_cond_q     <= ex_cond_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= rsp_illegal_d;
      flags_q       <= flags_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cntrl   = alu_cntrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_taken   = rsp_taken_q;
  assign rsp_illegal = rsp_illegal_q;
  assign flags_nzvc  = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl. Contains a stand-in 64-bit ALU (carry-chain
//   form, junk V/C on non-arithmetic ops) and an op-level reference model
//   that derives result/flags/taken from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [2:0]  cntrl;
    logic [63:0] a;
    logic [63:0] b;
    logic        setf;
    logic        bc;
    logic [3:0]  cond;
  } op_t;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cntrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_setflags;
  logic        req_is_bcond;
  logic [3:0]  req_cond;
  logic        flush;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_cntrl;
  logic [63:0] alu_result;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_taken;
  logic        rsp_illegal;
  logic [3:0]  flags_nzvc;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.WIDTH(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cntrl     (req_cntrl),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_setflags  (req_setflags),
    .req_is_bcond  (req_is_bcond),
    .req_cond      (req_cond),
    .flush         (flush),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_cntrl     (alu_cntrl),
    .alu_result    (alu_result),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .alu_carry_out (alu_carry_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_taken     (rsp_taken),
    .rsp_illegal   (rsp_illegal),
    .flags_nzvc    (flags_nzvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: 65-bit carry chain; V/C forced high on ops that do not
  // define them so a controller that fails to clear them is visible.
  logic [64:0] alu_sum;
  always_comb begin
    alu_sum       = '0;
    alu_result    = '0;
    alu_overflow  = 1'b1;
    alu_carry_out = 1'b1;
    case (alu_cntrl)
      3'b000: alu_result = alu_b;
      3'b010: begin
        alu_sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b011: begin
        alu_sum       = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = alu_a | alu_b;
      3'b110: alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a ^ ~alu_b;
    endcase
    alu_negative = alu_result[63];
    alu_zero     = (alu_result == 64'd0);
  end

  // ---------------- reference model ----------------
  function automatic logic cond_model(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, v, c, t;
    {n, z, v, c} = f;
    case (cd)
      4'd0:  t = z;
      4'd1:  t = !z;
      4'd2:  t = c;
      4'd3:  t = !c;
      4'd4:  t = n;
      4'd5:  t = !n;
      4'd6:  t = v;
      4'd7:  t = !v;
      4'd8:  t = c && !z;
      4'd9:  t = !c || z;
      4'd10: t = (n == v);
      4'd11: t = (n != v);
      4'd12: t = !z && (n == v);
      4'd13: t = z || (n != v);
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  function automatic void model_op(input op_t op, input logic [3:0] fl,
                                   output logic [63:0] res, output logic tk,
                                   output logic ill, output logic [3:0] nfl);
    logic [64:0] sx;
    logic n, z, v, c, arith;
    sx = '0; v = 1'b0; c = 1'b0; arith = 1'b0; ill = 1'b0; res = '0;
    case (op.cntrl)
      3'd0: res = op.b;
      3'd2: begin
        res = op.a + op.b;
        sx  = {op.a[63], op.a} + {op.b[63], op.b};
        v   = sx[64] ^ sx[63];
        c   = (res < op.a);
        arith = 1'b1;
      end
      3'd3: begin
        res = op.a - op.b;
        sx  = {op.a[63], op.a} - {op.b[63], op.b};
        v   = sx[64] ^ sx[63];
        c   = (op.a >= op.b);
        arith = 1'b1;
      end
      3'd4: res = op.a & op.b;
      3'd5: res = op.a | op.b;
      3'd6: res = op.a ^ op.b;
      default: begin ill = 1'b1; res = '0; end
    endcase
    n   = res[63];
    z   = (res == 64'd0);
    nfl = fl;
    if (op.setf && !op.bc && !ill) nfl = arith ? {n, z, v, c} : {n, z, 2'b00};
    tk  = op.bc ? cond_model(op.cond, fl) : 1'b0;
  endfunction

  function automatic op_t mk(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                             input logic sf, input logic bc, input logic [3:0] cd);
    op_t o;
    o.cntrl = c; o.a = a; o.b = b; o.setf = sf; o.bc = bc; o.cond = cd;
    return o;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t op);
    req_valid    = 1'b1;
    req_cntrl    = op.cntrl;
    req_a        = op.a;
    req_b        = op.b;
    req_setflags = op.setf;
    req_is_bcond = op.bc;
    req_cond     = op.cond;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; rsp_ready = 1'b1; flush = 1'b0; idle();
    req_cntrl = '0; req_a = '0; req_b = '0; req_setflags = 1'b0; req_is_bcond = 1'b0; req_cond = '0;
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_checks++; if ({alu_a, alu_b, alu_cntrl} !== '0) begin n_fail++; $display("FAIL reset_alu_regs got=%h/%h/%h exp=0", alu_a, alu_b, alu_cntrl); end
    n_checks++; if ({rsp_result, rsp_taken, rsp_illegal} !== '0) begin n_fail++; $display("FAIL reset_rsp_payload got=%h/%b/%b exp=0", rsp_result, rsp_taken, rsp_illegal); end
    n_checks++; if (flags_nzvc !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags_nzvc); end
    reset_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_adds_overflow();
    rsp_ready = 1'b1;
    drive(mk(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 4'd0));
    tick();  // accept edge T
    idle();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL adds_latency_early got=%b exp=0", rsp_valid); end
    n_checks++; if (alu_a !== 64'h7FFF_FFFF_FFFF_FFFF || alu_cntrl !== 3'b010) begin n_fail++; $display("FAIL adds_ex_regs got=%h/%b", alu_a, alu_cntrl); end
    tick();  // capture edge T+1
    $display("adds: rsp_valid=%b result=%h nzvc=%b", rsp_valid, rsp_result, flags_nzvc);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL adds_latency got=%b exp=1", rsp_valid); end
    n_checks++; if (rsp_result !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL adds_result got=%h exp=8000000000000000", rsp_result); end
    n_checks++; if (flags_nzvc !== 4'b1010) begin n_fail++; $display("FAIL adds_flags got=%b exp=1010", flags_nzvc); end
    n_checks++; if (rsp_illegal !== 1'b0 || rsp_taken !== 1'b0) begin n_fail++; $display("FAIL adds_side got=ill%b/tk%b exp=0/0", rsp_illegal, rsp_taken); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL adds_drop got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    drive(mk(3'b011, 64'd5, 64'd5, 1'b1, 1'b0, 4'd0));   // SUBS 5-5
    tick();
    drive(mk(3'b000, 64'd0, 64'd0, 1'b0, 1'b1, 4'd0));   // B.EQ
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", req_ready); end
    tick();
    $display("b2b: subs result=%h nzvc=%b", rsp_result, flags_nzvc);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd0) begin n_fail++; $display("FAIL b2b_subs_result got=v%b %h exp=v1 0", rsp_valid, rsp_result); end
    n_checks++; if (flags_nzvc !== 4'b0101) begin n_fail++; $display("FAIL b2b_subs_flags got=%b exp=0101", flags_nzvc); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", req_ready); end
    drive(mk(3'b000, 64'd0, 64'd0, 1'b0, 1'b1, 4'd1));   // B.NE
    tick();
    idle();
    $display("b2b: b.eq valid=%b taken=%b", rsp_valid, rsp_taken);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_beq got=v%b t%b exp=v1 t1", rsp_valid, rsp_taken); end
    tick();
    $display("b2b: b.ne valid=%b taken=%b", rsp_valid, rsp_taken);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0) begin n_fail++; $display("FAIL b2b_bne got=v%b t%b exp=v1 t0", rsp_valid, rsp_taken); end
    n_checks++; if (flags_nzvc !== 4'b0101) begin n_fail++; $display("FAIL b2b_bcond_noflags got=%b exp=0101", flags_nzvc); end
    tick();
  endtask

  task automatic test_stall();
    op_t oa, ob, oc;
    logic [63:0] ra, rb, rc;
    logic tk, ill;
    logic [3:0] nf;
    oa = mk(3'b010, rnd64(), rnd64(), 1'b0, 1'b0, 4'd0);
    ob = mk(3'b110, rnd64(), rnd64(), 1'b0, 1'b0, 4'd0);
    oc = mk(3'b011, rnd64(), rnd64(), 1'b0, 1'b0, 4'd0);
    model_op(oa, flags_nzvc, ra, tk, ill, nf);
    model_op(ob, flags_nzvc, rb, tk, ill, nf);
    model_op(oc, flags_nzvc, rc, tk, ill, nf);
    rsp_ready = 1'b0;
    drive(oa);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_a got=%b exp=1", req_ready); end
    tick();
    drive(ob);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_b got=%b exp=1", req_ready); end
    tick();
    drive(oc);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_c got=%b exp=0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== ra) begin n_fail++; $display("FAIL stall_rsp_a got=v%b %h exp=v1 %h", rsp_valid, rsp_result, ra); end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("stall: cycle %0d rsp=%h ready=%b", i, rsp_result, req_ready);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== ra) begin n_fail++; $display("FAIL stall_hold got=v%b %h exp=v1 %h", rsp_valid, rsp_result, ra); end
      n_checks++; if (req_ready !== 1'b0 || alu_a !== ob.a) begin n_fail++; $display("FAIL stall_ex_hold got=r%b %h exp=r0 %h", req_ready, alu_a, ob.a); end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", req_ready); end
    tick();
    idle();
    $display("stall: rsp b=%h", rsp_result);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== rb) begin n_fail++; $display("FAIL stall_rsp_b got=v%b %h exp=v1 %h", rsp_valid, rsp_result, rb); end
    tick();
    $display("stall: rsp c=%h", rsp_result);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== rc) begin n_fail++; $display("FAIL stall_rsp_c got=v%b %h exp=v1 %h", rsp_valid, rsp_result, rc); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    drive(mk(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 4'd0));  // ADDS -> 1, C
    tick();
    drive(mk(3'b111, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0));
    tick();
    idle();
    n_checks++; if (rsp_result !== 64'd1 || flags_nzvc !== 4'b0001) begin n_fail++; $display("FAIL illegal_pre got=%h/%b exp=1/0001", rsp_result, flags_nzvc); end
    tick();
    $display("illegal: valid=%b ill=%b result=%h nzvc=%b", rsp_valid, rsp_illegal, rsp_result, flags_nzvc);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got=v%b i%b exp=v1 i1", rsp_valid, rsp_illegal); end
    n_checks++; if (rsp_result !== 64'd0) begin n_fail++; $display("FAIL illegal_result got=%h exp=0", rsp_result); end
    n_checks++; if (flags_nzvc !== 4'b0001) begin n_fail++; $display("FAIL illegal_flags got=%b exp=0001", flags_nzvc); end
    tick();
  endtask

  task automatic test_flush();
    op_t ob;
    logic [63:0] rb;
    logic tk, ill;
    logic [3:0] nf, f0;
    rsp_ready = 1'b1;
    f0 = flags_nzvc;
    ob = mk(3'b010, rnd64(), rnd64(), 1'b0, 1'b0, 4'd0);
    model_op(ob, f0, rb, tk, ill, nf);
    drive(mk(3'b011, 64'd9, 64'd9, 1'b1, 1'b0, 4'd0));  // victim SUBS
    tick();
    drive(ob);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_killed got=%b exp=0", rsp_valid); end
    n_checks++; if (alu_a !== ob.a) begin n_fail++; $display("FAIL flush_newload got=%h exp=%h", alu_a, ob.a); end
    tick();
    $display("flush: valid=%b result=%h nzvc=%b", rsp_valid, rsp_result, flags_nzvc);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== rb) begin n_fail++; $display("FAIL flush_new_rsp got=v%b %h exp=v1 %h", rsp_valid, rsp_result, rb); end
    n_checks++; if (flags_nzvc !== f0) begin n_fail++; $display("FAIL flush_flags got=%b exp=%b", flags_nzvc, f0); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_reset_midstream();
    rsp_ready = 1'b0;
    drive(mk(3'b011, 64'd1, 64'd2, 1'b1, 1'b0, 4'd0));  // SUBS 1-2 -> N
    tick();
    drive(mk(3'b010, 64'd3, 64'd4, 1'b0, 1'b0, 4'd0));
    tick();
    idle();
    n_checks++; if (rsp_valid !== 1'b1 || flags_nzvc !== 4'b1000) begin n_fail++; $display("FAIL rstmid_pre got=v%b %b exp=v1 1000", rsp_valid, flags_nzvc); end
    #2;
    reset_n = 1'b0;
    #1;
    $display("rstmid: async reset valid=%b nzvc=%b", rsp_valid, flags_nzvc);
    n_checks++; if (rsp_valid !== 1'b0 || flags_nzvc !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async got=v%b %b exp=v0 0000", rsp_valid, flags_nzvc); end
    n_checks++; if (alu_a !== 64'd0 || rsp_result !== 64'd0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_regs got=%h/%h/r%b", alu_a, rsp_result, req_ready); end
    tick();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    drive(mk(3'b010, 64'd7, 64'd8, 1'b0, 1'b0, 4'd0));
    tick();
    idle();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_restart_early got=%b exp=0", rsp_valid); end
    tick();
    $display("rstmid: restart result=%h", rsp_result);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd15 || flags_nzvc !== 4'b0000) begin n_fail++; $display("FAIL rstmid_restart got=v%b %h %b exp=v1 f 0000", rsp_valid, rsp_result, flags_nzvc); end
    tick();
  endtask

  task automatic test_soak();
    op_t q[$];
    op_t o;
    logic [63:0] res;
    logic tk, ill;
    logic [3:0] nf, mflags;
    int n_rsp;
    reset_n = 1'b0; idle(); flush = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    mflags = 4'b0000;
    n_rsp  = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc < 600) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        o.cntrl = 3'($urandom_range(0, 7));
        o.a     = rnd64();
        o.b     = ($urandom_range(0, 3) == 0) ? o.a : rnd64();
        o.setf  = 1'($urandom_range(0, 1));
        o.bc    = ($urandom_range(0, 3) == 0);
        o.cond  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) drive(o); else idle();
      end else begin
        rsp_ready = 1'b1;
        idle();
      end
      @(negedge clk);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL soak_spurious rsp result=%h with nothing outstanding", rsp_result);
        end else begin
          model_op(q[0], mflags, res, tk, ill, nf);
          n_checks++; if (rsp_result !== res) begin n_fail++; $display("FAIL soak_result got=%h exp=%h", rsp_result, res); end
          n_checks++; if (rsp_taken !== tk) begin n_fail++; $display("FAIL soak_taken got=%b exp=%b", rsp_taken, tk); end
          n_checks++; if (rsp_illegal !== ill) begin n_fail++; $display("FAIL soak_illegal got=%b exp=%b", rsp_illegal, ill); end
          n_checks++; if (flags_nzvc !== nf) begin n_fail++; $display("FAIL soak_flags got=%b exp=%b", flags_nzvc, nf); end
          if (rsp_ready) begin
            $display("soak: rsp %0d cntrl=%b sf=%b bc=%b result=%h taken=%b nzvc=%b", n_rsp, q[0].cntrl, q[0].setf, q[0].bc, rsp_result, rsp_taken, flags_nzvc);
            mflags = nf;
            void'(q.pop_front());
            n_rsp++;
          end
        end
      end
      if (req_valid && req_ready) q.push_back({req_cntrl, req_a, req_b, req_setflags, req_is_bcond, req_cond});
      @(posedge clk);
      #1;
    end
    n_checks++; if (q.size() != 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL soak_drain got=%0d pending v%b exp=0 v0", q.size(), rsp_valid); end
    n_checks++; if (n_rsp < 100) begin n_fail++; $display("FAIL soak_volume got=%0d responses exp>=100", n_rsp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_adds_overflow();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_midstream();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
